// File: rtl/noop_ctrl_slave.sv
// AXI4-Lite control/status slave for the PS master: CTRL, STATUS, SCRATCH and a 64-bit cycle counter.
// Responses register one cycle after the AW+W or AR handshake and hold until bready/rready; one outstanding per channel.
module noop_ctrl_slave #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter logic [31:0] SCRATCH_RST = 32'h0
) (
  input  logic                  uncoreclk,
  input  logic                  uncore_aresetn,
  input  logic [ADDR_WIDTH-1:0] AXI_ZYNQ_awaddr,
  input  logic                  AXI_ZYNQ_awvalid,
  output logic                  AXI_ZYNQ_awready,
  input  logic [31:0]           AXI_ZYNQ_wdata,
  input  logic [3:0]            AXI_ZYNQ_wstrb,
  input  logic                  AXI_ZYNQ_wvalid,
  output logic                  AXI_ZYNQ_wready,
  output logic [1:0]            AXI_ZYNQ_bresp,
  output logic                  AXI_ZYNQ_bvalid,
  input  logic                  AXI_ZYNQ_bready,
  input  logic [ADDR_WIDTH-1:0] AXI_ZYNQ_araddr,
  input  logic                  AXI_ZYNQ_arvalid,
  output logic                  AXI_ZYNQ_arready,
  output logic [31:0]           AXI_ZYNQ_rdata,
  output logic [1:0]            AXI_ZYNQ_rresp,
  output logic                  AXI_ZYNQ_rvalid,
  input  logic                  AXI_ZYNQ_rready,
  input  logic [7:0]            trap_code,
  input  logic                  dcm_locked,
  output logic                  noop_rst_req
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] IDX_CTRL    = 3'd0;
  localparam logic [2:0] IDX_STATUS  = 3'd1;
  localparam logic [2:0] IDX_SCRATCH = 3'd2;
  localparam logic [2:0] IDX_CYC_LO  = 3'd3;
  localparam logic [2:0] IDX_CYC_HI  = 3'd4;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;

  logic [31:0] ctrl_q;
  logic [31:0] scratch_q;
  logic [31:0] cycle_snap_q;
  logic [63:0] cycle_cnt;
  logic [1:0]  dcm_sync_q;

  w_state_t    w_state, w_state_nxt;
  logic        aw_held_q, w_held_q;
  logic [2:0]  aw_idx_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [1:0]  bresp_q;
  logic        wr_commit;
  logic [2:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  r_state_t    r_state, r_state_nxt;
  logic        rd_accept;
  logic [2:0]  rd_idx;
  logic [31:0] rd_mux;
  logic [1:0]  rd_resp_mux;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^{AXI_ZYNQ_awaddr[ADDR_WIDTH-1:5], AXI_ZYNQ_awaddr[1:0],
                              AXI_ZYNQ_araddr[ADDR_WIDTH-1:5], AXI_ZYNQ_araddr[1:0]};

  // A beat latched earlier takes priority over the bus, which may already carry the next transaction.
  assign wr_idx  = aw_held_q ? aw_idx_q : AXI_ZYNQ_awaddr[4:2];
  assign wr_data = w_held_q  ? wdata_q  : AXI_ZYNQ_wdata;
  assign wr_strb = w_held_q  ? wstrb_q  : AXI_ZYNQ_wstrb;

  always_ff @(posedge uncoreclk or negedge uncore_aresetn) begin
    if (!uncore_aresetn) w_state <= W_IDLE;
    else                 w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = w_state;
    AXI_ZYNQ_awready = 1'b0;
    AXI_ZYNQ_wready  = 1'b0;
    AXI_ZYNQ_bvalid  = 1'b0;
    wr_commit        = 1'b0;
    case (w_state)
      W_IDLE: begin
        AXI_ZYNQ_awready = !aw_held_q;
        AXI_ZYNQ_wready  = !w_held_q;
        if ((aw_held_q || AXI_ZYNQ_awvalid) && (w_held_q || AXI_ZYNQ_wvalid)) begin
          wr_commit   = 1'b1;
          w_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        AXI_ZYNQ_bvalid = 1'b1;
        if (AXI_ZYNQ_bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge uncoreclk or negedge uncore_aresetn) begin
    if (!uncore_aresetn) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else if (wr_commit) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      bresp_q   <= (wr_idx > IDX_CYC_HI) ? RESP_SLVERR : RESP_OKAY;
    end else begin
      if (AXI_ZYNQ_awvalid && AXI_ZYNQ_awready) begin
        aw_held_q <= 1'b1;
        aw_idx_q  <= AXI_ZYNQ_awaddr[4:2];
      end
      if (AXI_ZYNQ_wvalid && AXI_ZYNQ_wready) begin
        w_held_q <= 1'b1;
        wdata_q  <= AXI_ZYNQ_wdata;
        wstrb_q  <= AXI_ZYNQ_wstrb;
      end
    end
  end

  // Writes to read-only or unmapped offsets fall through untouched here.
  always_ff @(posedge uncoreclk or negedge uncore_aresetn) begin
    if (!uncore_aresetn) begin
      ctrl_q    <= 32'h1;
      scratch_q <= SCRATCH_RST;
    end else if (wr_commit) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_strb[i] && wr_idx == IDX_CTRL)    ctrl_q[8*i +: 8]    <= wr_data[8*i +: 8];
        if (wr_strb[i] && wr_idx == IDX_SCRATCH) scratch_q[8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge uncoreclk or negedge uncore_aresetn) begin
    if (!uncore_aresetn) begin
      cycle_cnt  <= '0;
      dcm_sync_q <= '0;
    end else begin
      cycle_cnt  <= cycle_cnt + 64'd1;
      dcm_sync_q <= {dcm_sync_q[0], dcm_locked};
    end
  end

  assign rd_idx = AXI_ZYNQ_araddr[4:2];

  always_ff @(posedge uncoreclk or negedge uncore_aresetn) begin
    if (!uncore_aresetn) r_state <= R_IDLE;
    else                 r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt      = r_state;
    AXI_ZYNQ_arready = 1'b0;
    AXI_ZYNQ_rvalid  = 1'b0;
    rd_accept        = 1'b0;
    case (r_state)
      R_IDLE: begin
        AXI_ZYNQ_arready = 1'b1;
        if (AXI_ZYNQ_arvalid) begin
          rd_accept   = 1'b1;
          r_state_nxt = R_RESP;
        end
      end
      R_RESP: begin
        AXI_ZYNQ_rvalid = 1'b1;
        if (AXI_ZYNQ_rready) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // Register values seen here are pre-write, so a same-cycle write commit never leaks into read data.
  always_comb begin
    rd_mux      = '0;
    rd_resp_mux = RESP_OKAY;
    case (rd_idx)
      IDX_CTRL:    rd_mux = ctrl_q;
      IDX_STATUS:  rd_mux = {23'b0, dcm_sync_q[1], trap_code};
      IDX_SCRATCH: rd_mux = scratch_q;
      IDX_CYC_LO:  rd_mux = cycle_cnt[31:0];
      IDX_CYC_HI:  rd_mux = cycle_snap_q;
      default:     rd_resp_mux = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge uncoreclk or negedge uncore_aresetn) begin
    if (!uncore_aresetn) begin
      rdata_q      <= '0;
      rresp_q      <= RESP_OKAY;
      cycle_snap_q <= '0;
    end else if (rd_accept) begin
      rdata_q <= rd_mux;
      rresp_q <= rd_resp_mux;
      if (rd_idx == IDX_CYC_LO) cycle_snap_q <= cycle_cnt[63:32];
    end
  end

  assign AXI_ZYNQ_bresp = bresp_q;
  assign AXI_ZYNQ_rdata = rdata_q;
  assign AXI_ZYNQ_rresp = rresp_q;
  assign noop_rst_req   = ctrl_q[0];

endmodule

// File: tb/tb_noop_ctrl_slave.sv
// Bench for noop_ctrl_slave: directed register-map steps plus randomized AXI-Lite traffic checked
// against an offset-indexed register model.
`timescale 1ns/1ps
module tb_noop_ctrl_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic        awready, wready, bvalid, arready, rvalid, noop_rst_req;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [7:0]  trap_code = 8'h5A;
  logic        dcm_locked = 1'b1;

  always #5 clk = ~clk;

  noop_ctrl_slave #(.ADDR_WIDTH(32), .SCRATCH_RST(32'h0)) dut (
    .uncoreclk(clk), .uncore_aresetn(rst_n),
    .AXI_ZYNQ_awaddr(awaddr), .AXI_ZYNQ_awvalid(awvalid), .AXI_ZYNQ_awready(awready),
    .AXI_ZYNQ_wdata(wdata), .AXI_ZYNQ_wstrb(wstrb), .AXI_ZYNQ_wvalid(wvalid), .AXI_ZYNQ_wready(wready),
    .AXI_ZYNQ_bresp(bresp), .AXI_ZYNQ_bvalid(bvalid), .AXI_ZYNQ_bready(bready),
    .AXI_ZYNQ_araddr(araddr), .AXI_ZYNQ_arvalid(arvalid), .AXI_ZYNQ_arready(arready),
    .AXI_ZYNQ_rdata(rdata), .AXI_ZYNQ_rresp(rresp), .AXI_ZYNQ_rvalid(rvalid), .AXI_ZYNQ_rready(rready),
    .trap_code(trap_code), .dcm_locked(dcm_locked), .noop_rst_req(noop_rst_req)
  );

  int n_tests = 0;
  int n_fail  = 0;
  longint unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] m_ctrl, m_scratch, m_snap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s);
    logic [4:0] off;
    off = addr[4:0] & 5'h1C;
    case (off)
      5'h00: begin m_ctrl = merge(m_ctrl, d, s); return 2'b00; end
      5'h08: begin m_scratch = merge(m_scratch, d, s); return 2'b00; end
      5'h04, 5'h0C, 5'h10: return 2'b00;
      default: return 2'b10;
    endcase
  endfunction

  // The bench runs far fewer than 2^32 cycles, so the live high word is 0 whenever CYCLE_LO is read unforced.
  function automatic void model_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r,
                                     output bit chk);
    logic [4:0] off;
    off = addr[4:0] & 5'h1C;
    d = 32'h0; r = 2'b00; chk = 1'b1;
    case (off)
      5'h00: d = m_ctrl;
      5'h04: d = {23'b0, dcm_locked, trap_code};
      5'h08: d = m_scratch;
      5'h0C: begin chk = 1'b0; m_snap = 32'h0; end
      5'h10: d = m_snap;
      default: r = 2'b10;
    endcase
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s, input int w_lead,
                           output logic [1:0] resp, output int b_wait);
    int t_aw, t_w, n;
    bit aw_done, w_done, aw_fire, w_fire;
    t_aw = (w_lead > 0) ? w_lead : 0;
    t_w  = (w_lead < 0) ? -w_lead : 0;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = addr; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && n < 40) begin
      awvalid = !aw_done && (n >= t_aw);
      wvalid  = !w_done && (n >= t_w);
      @(negedge clk);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      n++;
    end
    awvalid = 0; wvalid = 0;
    check("wr_handshake", {aw_done, w_done}, 2'b11);
    b_wait = 0;
    while (!bvalid && b_wait < 20) begin @(posedge clk); #1; b_wait++; end
    check("bvalid_seen", bvalid, 1'b1);
    resp = bresp;
    bready = 1; @(posedge clk); #1; bready = 0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp,
                          output int r_wait, output longint unsigned ar_cyc);
    bit fired;
    int n;
    fired = 0; n = 0; ar_cyc = 0;
    araddr = addr; arvalid = 1;
    while (!fired && n < 40) begin
      @(negedge clk);
      fired  = arready;
      ar_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    arvalid = 0;
    check("ar_handshake", fired, 1'b1);
    r_wait = 0;
    while (!rvalid && r_wait < 20) begin @(posedge clk); #1; r_wait++; end
    check("rvalid_seen", rvalid, 1'b1);
    d = rdata; resp = rresp;
    rready = 1; @(posedge clk); #1; rready = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, ed, lo1, lo2, addr, wd;
    logic [1:0]  r, er, eb;
    int          w;
    bit          chk;
    longint unsigned c1, c2;
    int          idx;

    m_ctrl = 32'h1; m_scratch = 32'h0; m_snap = 32'h0;
    repeat (3) @(posedge clk); #1;
    check("rst_readies", {awready, wready, arready}, 3'b111);
    check("rst_valids", {bvalid, rvalid}, 2'b00);
    check("rst_resp_rdata", {bresp, rresp, rdata}, 36'h0);
    check("rst_noop_rst_req", noop_rst_req, 1'b1);
    rst_n = 1;
    repeat (3) @(posedge clk); #1;

    axi_read(32'h0, d, r, w, c1);
    check("t1_ctrl_rdata", d, 32'h1);
    check("t1_ctrl_rresp", r, 2'b00);
    check("t1_r_latency", w, 0);
    check("t1_noop_before", noop_rst_req, 1'b1);
    eb = model_write(32'h0, 32'h0, 4'hF);
    axi_write(32'h0, 32'h0, 4'hF, 0, r, w);
    check("t1_bresp", r, eb);
    check("t1_noop_after", noop_rst_req, 1'b0);

    eb = model_write(32'h8, 32'hDEADBEEF, 4'hF);
    axi_write(32'h8, 32'hDEADBEEF, 4'hF, 3, r, w);
    check("t2_bresp", r, eb);
    check("t2_b_latency", w, 0);
    axi_read(32'h8, d, r, w, c1);
    check("t2_scratch", d, 32'hDEADBEEF);

    eb = model_write(32'h8, 32'h11223344, 4'b0101);
    axi_write(32'h8, 32'h11223344, 4'b0101, -2, r, w);
    check("t3_bresp", r, eb);
    axi_read(32'h8, d, r, w, c1);
    check("t3_strobe_merge", d, 32'hDE22BE44);

    axi_read(32'h14, d, r, w, c1);
    check("t4_unmapped_rresp", r, 2'b10);
    check("t4_unmapped_rdata", d, 32'h0);
    eb = model_write(32'h1C, 32'hFFFFFFFF, 4'hF);
    axi_write(32'h1C, 32'hFFFFFFFF, 4'hF, 0, r, w);
    check("t4_unmapped_bresp", r, eb);
    eb = model_write(32'h4, 32'hFFFFFFFF, 4'hF);
    axi_write(32'h4, 32'hFFFFFFFF, 4'hF, 1, r, w);
    check("t4_ro_bresp", r, eb);
    axi_read(32'h8, d, r, w, c1);
    check("t4_scratch_kept", d, m_scratch);
    axi_read(32'h0, d, r, w, c1);
    check("t4_ctrl_kept", d, m_ctrl);

    trap_code = 8'hA5;
    axi_read(32'h4, d, r, w, c1);
    check("status_locked", d, 32'h1A5);
    dcm_locked = 0;
    repeat (3) @(posedge clk); #1;
    axi_read(32'h4, d, r, w, c1);
    check("status_unlocked", d, 32'h0A5);
    dcm_locked = 1;
    repeat (3) @(posedge clk); #1;

    axi_read(32'hC, lo1, r, w, c1);
    repeat ($urandom_range(1, 9)) @(posedge clk);
    #1;
    axi_read(32'hC, lo2, r, w, c2);
    check("cycle_lo_delta", lo2 - lo1, 32'(c2 - c1));
    m_snap = 32'h0;
    axi_read(32'h10, d, r, w, c1);
    check("cycle_hi_snapshot", d, m_snap);

    for (int i = 0; i < 60; i++) begin
      idx  = $urandom_range(0, 7);
      addr = ($urandom() & 32'hFFFF_FFE0) | (32'(idx) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        wd = $urandom();
        wstrb = 4'($urandom_range(0, 15));
        eb = model_write(addr, wd, wstrb);
        axi_write(addr, wd, wstrb, $urandom_range(0, 6) - 3, r, w);
        check("rnd_bresp", r, eb);
        check("rnd_noop_rst_req", noop_rst_req, m_ctrl[0]);
      end else begin
        trap_code = 8'($urandom());
        model_read(addr, ed, er, chk);
        axi_read(addr, d, r, w, c1);
        check("rnd_rresp", r, er);
        if (chk) check("rnd_rdata", d, ed);
      end
    end

    force dut.cycle_cnt = 64'h0000_0000_FFFF_FFFF;
    axi_read(32'hC, d, r, w, c1);
    release dut.cycle_cnt;
    check("t5_lo_at_carry", d, 32'hFFFF_FFFF);
    axi_read(32'h10, d, r, w, c1);
    check("t5_hi_at_carry", d, 32'h0);
    force dut.cycle_cnt = 64'h1234_5678_9ABC_DEF0;
    axi_read(32'hC, d, r, w, c1);
    release dut.cycle_cnt;
    check("t5_lo_pattern", d, 32'h9ABC_DEF0);
    repeat (4) @(posedge clk);
    #1;
    axi_read(32'h10, d, r, w, c1);
    check("t5_hi_pattern", d, 32'h1234_5678);

    ed = m_scratch;
    wd = $urandom();
    awaddr = 32'h8; wdata = wd; wstrb = 4'hF; araddr = 32'h8;
    awvalid = 1; wvalid = 1; arvalid = 1;
    @(negedge clk);
    check("t6_readies_before", {awready, wready, arready}, 3'b111);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; arvalid = 0;
    eb = model_write(32'h8, wd, 4'hF);
    for (int k = 0; k < 10; k++) begin
      check("t6_hold_ctl", {bvalid, rvalid, bresp, rresp, awready, wready, arready},
            {1'b1, 1'b1, eb, 2'b00, 3'b000});
      check("t6_hold_rdata_prewrite", rdata, ed);
      @(posedge clk); #1;
    end
    rst_n = 0;
    m_ctrl = 32'h1; m_scratch = 32'h0; m_snap = 32'h0;
    #1;
    check("t6_rst_valids", {bvalid, rvalid}, 2'b00);
    check("t6_rst_noop", noop_rst_req, 1'b1);
    @(posedge clk); #1;
    check("t6_rst_next_cycle", {bvalid, rvalid, noop_rst_req, awready, wready, arready}, 6'b001111);
    rst_n = 1;
    repeat (2) @(posedge clk); #1;
    axi_read(32'h0, d, r, w, c1);
    check("t6_ctrl_after_rst", d, m_ctrl);
    axi_read(32'h8, d, r, w, c1);
    check("t6_scratch_after_rst", d, m_scratch);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
